// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
//   Transfer sequencer between a host word stream and the single-word SPI
//   master spi_v2. Host TX words are queued in a FIFO. One spi_v2 transfer is
//   launched per word: the start level is raised and txdata is held for the
//   whole transfer. The controller then follows the master's busy signal and,
//   after a settle delay, captures rxdata into an RX FIFO for the host.
//
// Ports
//   clk_i, rst_i        core clock (shared with spi_v2); async active-low reset
//   tx_data_i/valid_i   host TX word stream; tx_ready_o = TX FIFO not full
//   rx_data_o/valid_o   head of RX FIFO (first-word-fall-through); rx_ready_i pops
//   spi_start_o         to spi_v2 start_i (level, registered)
//   spi_txdata_o        to spi_v2 txdata_i, stable while active_o=1
//   spi_rxdata_i        from spi_v2 rxdata_o
//   spi_busy_i          from spi_v2 busy
//   active_o            1 whenever the sequencer is not idle
//   err_o / err_clr_i   sticky busy-timeout flag; a clear beats a same-cycle set
// -----------------------------------------------------------------------------

// Synchronous first-word-fall-through FIFO with 2**AW entries.
//   push/wr_data  write request (ignored when full, even with a same-cycle pop)
//   pop           read request (ignored when empty)
//   rd_data       head word; reads as zero while empty
//   full, empty   occupancy flags
module spi_xfer_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_r [2**AW];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (cnt_r == DEPTH_C);
  assign empty     = (cnt_r == {(AW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rd_data   = empty ? {W{1'b0}} : mem_r[rd_ptr_r];

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally at 2**AW; the count is one bit wider to tell full from empty
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end
endmodule

module spi_xfer_ctrl #(
  parameter int DATA_SIZE    = 8,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 15,
  parameter int SETTLE       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 spi_start_o,
  output logic [DATA_SIZE-1:0] spi_txdata_o,
  input  logic [DATA_SIZE-1:0] spi_rxdata_i,
  input  logic                 spi_busy_i,
  output logic                 active_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);
  localparam int TMAX = (BUSY_TIMEOUT > SETTLE) ? BUSY_TIMEOUT : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_DONE = 3'd2,
    SETTLE_ST = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t                 state_r, state_n;
  logic [TW-1:0]          timer_r, timer_n;
  logic [DATA_SIZE-1:0]   txdata_r, txdata_n;
  logic                   start_r, active_r, err_r, err_n;
  logic                   err_set_s;
  logic                   tx_pop_s, rx_push_s;
  logic [DATA_SIZE-1:0]   tx_head_s;
  logic                   tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;

  spi_xfer_fifo #(.W(DATA_SIZE), .AW(AW)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (tx_valid_i),
    .wr_data (tx_data_i),
    .pop     (tx_pop_s),
    .rd_data (tx_head_s),
    .full    (tx_full_s),
    .empty   (tx_empty_s)
  );

  spi_xfer_fifo #(.W(DATA_SIZE), .AW(AW)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (rx_push_s),
    .wr_data (spi_rxdata_i),
    .pop     (rx_ready_i),
    .rd_data (rx_data_o),
    .full    (rx_full_s),
    .empty   (rx_empty_s)
  );

  assign tx_ready_o   = ~tx_full_s;
  assign rx_valid_o   = ~rx_empty_s;
  assign spi_start_o  = start_r;
  assign spi_txdata_o = txdata_r;
  assign active_o     = active_r;
  assign err_o        = err_r;

  // Next-state logic; outputs are derived from the next state so they come straight off flops
  always_comb begin
    state_n   = state_r;
    timer_n   = timer_r;
    txdata_n  = txdata_r;
    tx_pop_s  = 1'b0;
    rx_push_s = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Launch only while the RX FIFO has a free slot, so the later capture cannot overflow
        if (!tx_empty_s && !rx_full_s) begin
          tx_pop_s = 1'b1;
          txdata_n = tx_head_s;
          timer_n  = {TW{1'b0}};
          state_n  = LAUNCH;
        end else begin
          state_n  = IDLE;
        end
      end
      LAUNCH: begin
        if (spi_busy_i) begin
          state_n = WAIT_DONE;
        end else if (timer_r == TO_LAST) begin
          err_set_s = 1'b1;
          state_n   = GAP;
        end else begin
          timer_n = timer_r + T_ONE;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy_i) begin
          timer_n = {TW{1'b0}};
          state_n = SETTLE_ST;
        end else begin
          state_n = WAIT_DONE;
        end
      end
      SETTLE_ST: begin
        if (timer_r == SET_LAST) begin
          rx_push_s = 1'b1;
          state_n   = GAP;
        end else begin
          timer_n = timer_r + T_ONE;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    err_n = err_clr_i ? 1'b0 : (err_r | err_set_s);
  end

  // Sequencer state, timer and all registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= IDLE;
      timer_r  <= {TW{1'b0}};
      txdata_r <= {DATA_SIZE{1'b0}};
      start_r  <= 1'b0;
      active_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      timer_r  <= timer_n;
      txdata_r <= txdata_n;
      start_r  <= (state_n == LAUNCH);
      active_r <= (state_n != IDLE);
      err_r    <= err_n;
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;
  localparam int DW = 8;
  localparam int BT = 15;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] tx_data_i = 8'h00;
  logic          tx_valid_i = 1'b0;
  logic          tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i = 1'b0;
  logic          spi_start_o;
  logic [DW-1:0] spi_txdata_o;
  logic [DW-1:0] spi_rxdata_i;
  logic          spi_busy_i;
  logic          active_o;
  logic          err_o;
  logic          err_clr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_xfer_ctrl #(.DATA_SIZE(DW), .AW(4), .BUSY_TIMEOUT(BT), .SETTLE(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .spi_start_o(spi_start_o), .spi_txdata_o(spi_txdata_o),
    .spi_rxdata_i(spi_rxdata_i), .spi_busy_i(spi_busy_i),
    .active_o(active_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  // spi_v2 stand-in: on a start rise, capture txdata^key, raise busy after a short
  // random delay, drive garbage on rxdata while busy, then present the reply as busy falls.
  logic          busy_en = 1'b1;
  logic [DW-1:0] key = 8'h00;
  int            m_state, m_cnt;
  logic          start_q;
  logic [DW-1:0] m_cap;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      spi_busy_i <= 1'b0; spi_rxdata_i <= 8'h00; start_q <= 1'b0;
      m_state <= 0; m_cnt <= 0; m_cap <= 8'h00;
    end else begin
      start_q <= spi_start_o;
      case (m_state)
        0: if (spi_start_o && !start_q && busy_en) begin
             m_cap <= spi_txdata_o ^ key; m_cnt <= int'($urandom_range(3, 0)); m_state <= 1;
           end
        1: if (m_cnt == 0) begin
             spi_busy_i <= 1'b1; m_cnt <= int'($urandom_range(20, 6)); m_state <= 2;
           end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 0) begin
             spi_busy_i <= 1'b0; spi_rxdata_i <= m_cap; m_state <= 0;
           end else begin
             spi_rxdata_i <= 8'($urandom); m_cnt <= m_cnt - 1;
           end
      endcase
    end
  end

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic track = 1'b0;
  logic prev_start = 1'b0, prev_active = 1'b0;
  logic [DW-1:0] prev_txdata = 8'h00;
  int low_cnt = 99, hi_cnt = 0, last_hi = 0, rise_cnt = 0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %b, want %b", nm, act, exp); end
  endtask
  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %02h, want %02h", nm, act, exp); end
  endtask
  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin n_bad++; $display("FAIL %s: got %0d, want %0d", nm, act, exp); end
  endtask

  // One clock: book host handshakes into the reference queue, advance, sample at +1.
  task automatic tick();
    if (track && tx_valid_i && tx_ready_o) exp_q.push_back(tx_data_i ^ key);
    if (track && rx_valid_o && rx_ready_i) begin
      chk_b("rx_word_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk_w("rx_data_order", rx_data_o, exp_q.pop_front());
    end
    @(posedge clk_i); #1;
    if (spi_start_o && !prev_start) begin
      rise_cnt++;
      chk_b("start_low_gap_ge2", low_cnt >= 2, 1'b1);
      low_cnt = 0; hi_cnt = 0;
    end
    if (spi_start_o) hi_cnt++;
    else begin
      if (prev_start) last_hi = hi_cnt;
      low_cnt++;
    end
    if (active_o && prev_active) chk_w("txdata_stable", spi_txdata_o, prev_txdata);
    prev_start = spi_start_o; prev_active = active_o; prev_txdata = spi_txdata_o;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    logic acc;
    acc = 1'b0;
    tx_data_i = w; tx_valid_i = 1'b1;
    for (int k = 0; k < 3000 && !acc; k++) begin acc = tx_ready_o; tick(); end
    tx_valid_i = 1'b0;
    chk_b("push_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    rx_ready_i = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if (exp_q.size() == 0 && !active_o && !rx_valid_o) break;
      tick();
    end
    chk_i("drain_queue_left", exp_q.size(), 0);
    chk_b("drain_rx_valid", rx_valid_o, 1'b0);
    chk_b("drain_active", active_o, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_b({tag, "_tx_ready"}, tx_ready_o, 1'b1);
    chk_b({tag, "_rx_valid"}, rx_valid_o, 1'b0);
    chk_w({tag, "_rx_data"}, rx_data_o, 8'h00);
    chk_b({tag, "_start"}, spi_start_o, 1'b0);
    chk_w({tag, "_txdata"}, spi_txdata_o, 8'h00);
    chk_b({tag, "_active"}, active_o, 1'b0);
    chk_b({tag, "_err"}, err_o, 1'b0);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] k;
    logic          busy_en;
    logic          exp_valid;
    logic [DW-1:0] exp_rx;
    logic          exp_err;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int base, seen_rx, seen_rise;
    vecs[0] = '{tx: 8'hA5, k: 8'h00, busy_en: 1'b1, exp_valid: 1'b1, exp_rx: 8'hA5, exp_err: 1'b0};
    vecs[1] = '{tx: 8'h00, k: 8'h00, busy_en: 1'b1, exp_valid: 1'b1, exp_rx: 8'h00, exp_err: 1'b0};
    vecs[2] = '{tx: 8'hFF, k: 8'h00, busy_en: 1'b1, exp_valid: 1'b1, exp_rx: 8'hFF, exp_err: 1'b0};
    vecs[3] = '{tx: 8'h5A, k: 8'hFF, busy_en: 1'b1, exp_valid: 1'b1, exp_rx: 8'hA5, exp_err: 1'b0};
    vecs[4] = '{tx: 8'h81, k: 8'h3C, busy_en: 1'b1, exp_valid: 1'b1, exp_rx: 8'hBD, exp_err: 1'b0};
    vecs[5] = '{tx: 8'h3C, k: 8'h00, busy_en: 1'b0, exp_valid: 1'b0, exp_rx: 8'h00, exp_err: 1'b1};

    #2 rst_i = 1'b0; #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    tick();

    // Single-word transfers, including a busy timeout
    for (int i = 0; i < 6; i++) begin
      key = vecs[i].k; busy_en = vecs[i].busy_en;
      push_word(vecs[i].tx);
      for (int k = 0; k < 300 && !(rx_valid_o || err_o); k++) tick();
      for (int k = 0; k < 50 && active_o; k++) tick();
      chk_b("vec_rx_valid", rx_valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk_w("vec_rx_data", rx_data_o, vecs[i].exp_rx);
      chk_b("vec_err", err_o, vecs[i].exp_err);
      chk_b("vec_start_low", spi_start_o, 1'b0);
      chk_b("vec_active_idle", active_o, 1'b0);
      if (vecs[i].exp_err) chk_i("timeout_start_cycles", last_hi, BT);
      rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
      chk_b("vec_rx_once", rx_valid_o, 1'b0);
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      chk_b("vec_err_cleared", err_o, 1'b0);
    end

    // A clear held through a timeout wins over the set
    busy_en = 1'b0; err_clr_i = 1'b1;
    push_word(8'h11);
    for (int k = 0; k < 10 && !active_o; k++) tick();
    for (int k = 0; k < 60 && active_o; k++) tick();
    chk_b("clr_wins_err", err_o, 1'b0);
    err_clr_i = 1'b0; tick();
    chk_b("clr_wins_err_after", err_o, 1'b0);
    chk_b("clr_wins_no_rx", rx_valid_o, 1'b0);
    busy_en = 1'b1;

    // Burst of 16 with the host always ready
    track = 1'b1; key = 8'h00; rx_ready_i = 1'b1;
    base = rise_cnt;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    drain();
    chk_i("burst16_transfers", rise_cnt - base, 16);

    // Host stalled: 16 transfers fill RX, the rest stay queued until it reads
    rx_ready_i = 1'b0; base = rise_cnt;
    for (int i = 0; i < 20; i++) push_word(8'($urandom));
    for (int k = 0; k < 3000 && !((rise_cnt - base) >= 16 && !active_o); k++) tick();
    repeat (100) tick();
    chk_i("stall_transfers", rise_cnt - base, 16);
    chk_b("stall_parked_idle", active_o, 1'b0);
    chk_b("stall_tx_not_full", tx_ready_o, 1'b1);
    chk_b("stall_rx_valid", rx_valid_o, 1'b1);
    drain();
    chk_i("stall_total_transfers", rise_cnt - base, 20);

    // Full TX FIFO refuses a push in the same cycle the sequencer pops it
    rx_ready_i = 1'b0; base = rise_cnt;
    for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
    for (int k = 0; k < 3000 && !((rise_cnt - base) >= 16 && !active_o); k++) tick();
    for (int i = 0; i < 16; i++) push_word(8'(8'h80 + i));
    chk_b("full_tx_ready_low", tx_ready_o, 1'b0);
    tx_data_i = 8'hEE; tx_valid_i = 1'b1; rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    chk_b("full_still_full", tx_ready_o, 1'b0);
    tick();
    tx_valid_i = 1'b0;
    chk_b("full_pop_frees_slot", tx_ready_o, 1'b1);
    chk_b("full_launched", active_o, 1'b1);
    drain();
    chk_i("full_total_transfers", rise_cnt - base, 32);

    // Randomized traffic against the reference queue
    key = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      tx_valid_i = ($urandom_range(2, 0) == 0);
      tx_data_i  = 8'($urandom);
      rx_ready_i = ($urandom_range(3, 0) != 0);
      tick();
    end
    tx_valid_i = 1'b0;
    drain();

    // Asynchronous reset while waiting for busy to fall, with words queued
    track = 1'b0; exp_q.delete(); key = 8'h00; rx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
    for (int k = 0; k < 200 && !(spi_busy_i && !spi_start_o && active_o); k++) tick();
    chk_b("rst_reached_wait_done", spi_busy_i && !spi_start_o && active_o, 1'b1);
    rst_i = 1'b0; #1;
    check_reset_outputs("midrst");
    tick(); tick();
    rst_i = 1'b1;
    seen_rx = 0; base = rise_cnt;
    for (int k = 0; k < 60; k++) begin tick(); if (rx_valid_o) seen_rx++; end
    seen_rise = rise_cnt - base;
    chk_i("midrst_no_rx", seen_rx, 0);
    chk_i("midrst_no_launch", seen_rise, 0);
    chk_b("midrst_tx_ready", tx_ready_o, 1'b1);
    track = 1'b1; rx_ready_i = 1'b1;
    push_word(8'h96);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
